xs3_to_bcd_serial: RTL and testbench
====================================

Name: xs3_to_bcd_serial

Overview:
- Serial Excess-3 → BCD converter: the decode end of the team's serial BCD → Excess-3 converter.
- Takes one Excess-3 bit per enabled clock, LSB first, in 4-bit digit groups; emits the matching BCD bit as a Mealy output (X − 3, serial subtract with borrow).
- Assembles each completed digit in parallel, flags invalid Excess-3 codes, and counts digits.
- Sits downstream of the converter or of any serial Excess-3 source in the datapath.

Parameters:
- CNT_W, 4, width of the completed-digit counter DigitCnt (wraps modulo 2^CNT_W).

Ports:
- CLK  in  1  system clock; all registers update on falling edge, same as the rest of the converter.
- ClrN  in  1  asynchronous active-low clear.
- En  in  1  bit-valid qualifier; X is consumed only on falling CLK edges where En=1.
- X  in  1  serial Excess-3 input bit, LSB first.
- Z  out  1  serial BCD output bit (combinational, Mealy); 0 whenever En=0.
- BitPos  out  2  index of the bit expected next (0..3).
- DigitDone  out  1  registered one-cycle pulse after the 4th bit of a digit is consumed.
- Err  out  1  registered, asserted with DigitDone when the completed code is not valid Excess-3.
- Dout  out  4  last completed BCD digit, parallel, MSB at [3]; loaded on the DigitDone edge.
- DigitCnt  out  CNT_W  number of completed digits, wrapping.

Behaviour:
- Reset (ClrN=0, async, any time including mid-digit):
  - FSM → B0; BitPos=0; DigitDone=0; Err=0; Dout=0; DigitCnt=0; internal shift register and borrow = 0.
  - A partial digit is discarded.
- FSM states (bit index, borrow-in): B0 (bit0, b=0), B1N/B1B, B2N/B2B, B3N/B3B (bits 1–3, b=0/1). Seven states.
- Subtrahend bits of 3 (0011): s0=1, s1=1, s2=0, s3=0.
- Mealy output: Z = En & (X ^ s_i ^ b).
- Borrow-out: b' = (~X & (s_i | b)) | (s_i & b).
- Transitions on each enabled edge:
  - B0 → B1(b'); B1x → B2(b'); B2x → B3(b'); B3x → B0. Borrow is cleared at every digit boundary.
  - En=0: state, BitPos and the shift register hold; no digit activity.
- BitPos follows the FSM: 0 in B0, 1 in B1x, 2 in B2x, 3 in B3x.
- Each enabled edge shifts Z into a 4-bit shift register, LSB first.
- On the enabled edge leaving B3x (same edge, registered):
  - DigitDone=1 for exactly one cycle.
  - Dout = assembled 4 bits.
  - DigitCnt increments; 2^CNT_W−1 wraps to 0.
  - Err=1 if final borrow-out b'=1 (code < 3) or assembled result > 9 (code > 12); otherwise Err=0.
  - Dout is loaded even when Err=1 (raw subtraction bits).
- DigitDone and Err are 0 on every other edge, including edges where the 4th bit arrives with En=0 and edges in B0–B2.
- Back-to-back digits: bit0 of the next digit can be consumed on the edge right after the 4th bit; no idle cycle.
- Latency: Z is same-cycle combinational; the parallel digit is available one falling edge after bit3 is sampled.

Test Plan:
- Reset then En=1, X=0,1,0,1 (Excess-3 1010 = 7) → Z=1,1,1,0; DigitDone pulse; Dout=0111; Err=0; DigitCnt=1.
- X=1,1,0,0 (0011) → Z=0,0,0,0; Dout=0000; Err=0. Then X=0,0,1,1 (1100) → Dout=1001, Err=0, with no gap between digits.
- X=1,0,0,0 (0001) → final borrow=1 → Err=1 with DigitDone. Separately X=1,1,1,1 (1111 → result 1100) → Err=1, Dout=1100.
- Digit 7 sent with En=0 for 3 cycles between bits 1 and 2 → Z=0 and BitPos frozen while stalled; result identical to the unstalled case; single DigitDone.
- ClrN pulsed low asynchronously after 2 bits → all outputs 0 immediately; next 4 bits 0,1,0,1 decode as a fresh digit 7.
- CNT_W=2, 5 valid digits → DigitCnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/xs3_to_bcd_serial.sv
// Serial Excess-3 to BCD decoder. It subtracts 3 bit-serially, LSB first, and produces a Mealy output bit.
// It also assembles each completed digit, flags invalid codes and counts the completed digits.
module xs3_to_bcd_serial #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             ClrN,
    input  logic             En,
    input  logic             X,
    output logic             Z,
    output logic [1:0]       BitPos,
    output logic             DigitDone,
    output logic             Err,
    output logic [3:0]       Dout,
    output logic [CNT_W-1:0] DigitCnt
);

    // The state encodes the bit index and the borrow-in. Bit 0 never carries a borrow.
    typedef enum logic [2:0] {
        B0, B1N, B1B, B2N, B2B, B3N, B3B
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sr_q, sr_d;
    logic [3:0]       dout_q, dout_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       bit_idx;
    logic             borrow_in;
    logic             sub_bit;
    logic             borrow_out;
    logic [3:0]       digit;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        bit_idx   = 2'd0;
        borrow_in = 1'b0;
        unique case (state_q)
            B0:      begin bit_idx = 2'd0; borrow_in = 1'b0; end
            B1N:     begin bit_idx = 2'd1; borrow_in = 1'b0; end
            B1B:     begin bit_idx = 2'd1; borrow_in = 1'b1; end
            B2N:     begin bit_idx = 2'd2; borrow_in = 1'b0; end
            B2B:     begin bit_idx = 2'd2; borrow_in = 1'b1; end
            B3N:     begin bit_idx = 2'd3; borrow_in = 1'b0; end
            B3B:     begin bit_idx = 2'd3; borrow_in = 1'b1; end
            default: begin bit_idx = 2'd0; borrow_in = 1'b0; end
        endcase

        // The subtrahend 0011 has ones only in bits 0 and 1.
        sub_bit    = ~bit_idx[1];
        Z          = En & (X ^ sub_bit ^ borrow_in);
        borrow_out = (~X & (sub_bit | borrow_in)) | (sub_bit & borrow_in);
        digit      = {Z, sr_q[3:1]};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (En) begin
            sr_d = digit;
            unique case (state_q)
                B0:       state_d = borrow_out ? B1B : B1N;
                B1N, B1B: state_d = borrow_out ? B2B : B2N;
                B2N, B2B: state_d = borrow_out ? B3B : B3N;
                B3N, B3B: begin
                    state_d = B0;
                    done_d  = 1'b1;
                    dout_d  = digit;
                    // A final borrow means the code was below 3. A result above 9 means the code was above 12.
                    err_d   = borrow_out | (digit > 4'd9);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default:  state_d = B0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(negedge CLK or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= B0;
            sr_q    <= 4'd0;
            dout_q  <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BitPos    = bit_idx;
    assign DigitDone = done_q;
    assign Err       = err_q;
    assign Dout      = dout_q;
    assign DigitCnt  = cnt_q;

endmodule

// File: tb/tb_xs3_to_bcd_serial.sv
// Scoreboard bench for xs3_to_bcd_serial. Expected results are derived arithmetically from each code (code - 3).
// A monitor compares the per-bit Z/BitPos values and the completed-digit outputs. A CNT_W=2 copy exercises counter wrap.
module tb_xs3_to_bcd_serial;

    logic       CLK = 1'b0;
    logic       ClrN;
    logic       En;
    logic       X;
    logic       Z, Z2;
    logic [1:0] BitPos, BitPos2;
    logic       DigitDone, DigitDone2;
    logic       Err, Err2;
    logic [3:0] Dout, Dout2;
    logic [3:0] DigitCnt;
    logic [1:0] DigitCnt2;

    xs3_to_bcd_serial #(.CNT_W(4)) dut (
        .CLK(CLK), .ClrN(ClrN), .En(En), .X(X), .Z(Z), .BitPos(BitPos),
        .DigitDone(DigitDone), .Err(Err), .Dout(Dout), .DigitCnt(DigitCnt)
    );

    xs3_to_bcd_serial #(.CNT_W(2)) dut2 (
        .CLK(CLK), .ClrN(ClrN), .En(En), .X(X), .Z(Z2), .BitPos(BitPos2),
        .DigitDone(DigitDone2), .Err(Err2), .Dout(Dout2), .DigitCnt(DigitCnt2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       z;
        logic [1:0] pos;
    } cyc_t;

    typedef struct {
        logic [3:0] dout;
        logic       err;
        logic [3:0] cnt4;
        logic [1:0] cnt2;
    } dig_t;

    cyc_t cyc_q[$];
    dig_t dig_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   digit_count = 0;
    int   pos_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle. The expected Z and BitPos for this cycle are queued for the monitor.
    task automatic cycle(input logic en, input logic x, input logic zexp);
        cyc_t c;
        @(posedge CLK);
        En = en;
        X  = x;
        c.z   = zexp;
        c.pos = 2'(pos_m);
        cyc_q.push_back(c);
        if (en) pos_m = (pos_m + 1) % 4;
    endtask

    task automatic send_digit(input logic [3:0] code, input int stall_at, input int stall_len,
                              input bit rnd_stall);
        logic [3:0] diff;
        dig_t       d;
        int         n;
        diff = code - 4'd3;
        for (int i = 0; i < 4; i++) begin
            n = (i == stall_at) ? stall_len : 0;
            if (rnd_stall && $urandom_range(0, 3) == 0) n += int'($urandom_range(1, 2));
            for (int s = 0; s < n; s++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cycle(1'b1, code[i], diff[i]);
        end
        digit_count++;
        d.dout = diff;
        d.err  = (code < 4'd3) || (code > 4'd12);
        d.cnt4 = 4'(digit_count % 16);
        d.cnt2 = 2'(digit_count % 4);
        dig_q.push_back(d);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_bitpos"}, 32'(BitPos), 0);
        check({tag, "_done"}, 32'(DigitDone), 0);
        check({tag, "_err"}, 32'(Err), 0);
        check({tag, "_dout"}, 32'(Dout), 0);
        check({tag, "_cnt"}, 32'(DigitCnt), 0);
        check({tag, "_cnt2"}, 32'(DigitCnt2), 0);
        check({tag, "_z"}, 32'(Z), 0);
    endtask

    // Monitor: samples well away from the falling (active) edge.
    initial begin
        cyc_t c;
        dig_t d;
        forever begin
            @(posedge CLK);
            #2;
            if (ClrN) begin
                if (cyc_q.size() > 0) begin
                    c = cyc_q.pop_front();
                    check("z", 32'(Z), 32'(c.z));
                    check("bitpos", 32'(BitPos), 32'(c.pos));
                end
                if (DigitDone) begin
                    if (dig_q.size() == 0) begin
                        check("spurious_done", 32'(DigitDone), 0);
                    end else begin
                        d = dig_q.pop_front();
                        check("dout", 32'(Dout), 32'(d.dout));
                        check("err", 32'(Err), 32'(d.err));
                        check("digitcnt", 32'(DigitCnt), 32'(d.cnt4));
                        check("dout_w2", 32'(Dout2), 32'(d.dout));
                        check("digitcnt_w2", 32'(DigitCnt2), 32'(d.cnt2));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ClrN = 1'b0;
        En   = 1'b0;
        X    = 1'b0;
        #3;
        check_cleared("reset");
        @(posedge CLK);
        ClrN = 1'b1;

        // Directed digits, sent back-to-back: 7, 0, 9, then the invalid codes 1 and 15.
        send_digit(4'b1010, -1, 0, 1'b0);
        send_digit(4'b0011, -1, 0, 1'b0);
        send_digit(4'b1100, -1, 0, 1'b0);
        send_digit(4'b0001, -1, 0, 1'b0);
        send_digit(4'b1111, -1, 0, 1'b0);

        // Digit 7 with a three-cycle stall between bits 1 and 2.
        send_digit(4'b1010, 2, 3, 1'b0);

        // Asynchronous clear after two bits of a digit. The partial digit is discarded.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        #4;
        ClrN = 1'b0;
        #1;
        check_cleared("async_clr");
        pos_m       = 0;
        digit_count = 0;
        @(posedge CLK);
        ClrN = 1'b1;
        send_digit(4'b1010, -1, 0, 1'b0);

        // Random codes with random stalls. The digit counters wrap several times.
        for (int k = 0; k < 40; k++) send_digit(4'($urandom_range(0, 15)), -1, 0, 1'b1);

        for (int k = 0; k < 4; k++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        @(posedge CLK);
        #3;
        check("pending_digits", 32'(dig_q.size()), 0);
        check("pending_cycles", 32'(cyc_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
